// File: rtl/rv32i_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle sequencer: opcodes, FSM states,
// instruction classes and datapath mux codes.
package rv32i_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CLS_NONE,
    CLS_R,
    CLS_IALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_LUI,
    CLS_AUIPC,
    CLS_JAL,
    CLS_JALR
  } insn_class_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_PASSB = 2'b11;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JAL    = 2'b10;
  localparam logic [1:0] PC_JALR   = 2'b11;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

  function automatic insn_class_t decode_class(input logic [6:0] op);
    insn_class_t cls;
    case (op)
      OP_R:      cls = CLS_R;
      OP_IALU:   cls = CLS_IALU;
      OP_LOAD:   cls = CLS_LOAD;
      OP_STORE:  cls = CLS_STORE;
      OP_BRANCH: cls = CLS_BRANCH;
      OP_LUI:    cls = CLS_LUI;
      OP_AUIPC:  cls = CLS_AUIPC;
      OP_JAL:    cls = CLS_JAL;
      OP_JALR:   cls = CLS_JALR;
      default:   cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Memory wait counter: counts stalled cycles and flags the last allowed one.
// LIMIT = 0 disables expiry.
module wait_timer #(
  parameter int unsigned LIMIT = 15,
  parameter int unsigned W     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Asserted during the LIMIT-th consecutive stalled cycle.
  assign expired = (LIMIT != 0) && (count == W'(LIMIT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: steps the shared datapath through
// FETCH/DECODE/EXEC/MEM/WB and handshakes with instruction/data memories.
module multicycle_ctrl
  import rv32i_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TMO_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic       alu_src1,
  output logic       alu_src2,
  output logic [1:0] mem_to_reg,
  output logic       reg_write,
  output logic       illegal,
  output logic       timeout,
  output logic [2:0] state
);

  state_t      state_q, state_d;
  insn_class_t cls_q, cls_d;
  logic        illegal_q, illegal_d;
  logic        timeout_q, timeout_d;
  logic        waiting, ready, tmo_expired;

  assign waiting = (state_q == S_FETCH) || (state_q == S_MEM);
  assign ready   = ((state_q == S_FETCH) && imem_ready) ||
                   ((state_q == S_MEM)   && dmem_ready);

  wait_timer #(
    .LIMIT (MEM_TIMEOUT),
    .W     (TMO_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!waiting || ready),
    .enable  (waiting && !ready),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cls_q     <= CLS_NONE;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    illegal_d  = illegal_q;
    timeout_d  = timeout_q;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_PLUS4;
    alu_op     = ALU_ADD;
    alu_src1   = 1'b0;
    alu_src2   = 1'b0;
    mem_to_reg = WB_ALU;
    reg_write  = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_PLUS4;
          state_d  = S_DECODE;
        end else if (tmo_expired) begin
          timeout_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_DECODE: begin
        cls_d = decode_class(opcode);
        if (decode_class(opcode) == CLS_NONE) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_WB;
        case (cls_q)
          CLS_R: alu_op = ALU_FUNCT;
          CLS_IALU: begin
            alu_op   = ALU_FUNCT;
            alu_src2 = 1'b1;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_op   = ALU_ADD;
            alu_src2 = 1'b1;
            state_d  = S_MEM;
          end
          CLS_BRANCH: begin
            alu_op   = ALU_SUB;
            pc_write = zero;
            pc_src   = PC_BRANCH;
            state_d  = S_FETCH;
          end
          CLS_LUI: begin
            alu_op   = ALU_PASSB;
            alu_src2 = 1'b1;
          end
          CLS_AUIPC: begin
            alu_op   = ALU_ADD;
            alu_src1 = 1'b1;
            alu_src2 = 1'b1;
          end
          CLS_JAL: begin
            pc_write = 1'b1;
            pc_src   = PC_JAL;
          end
          CLS_JALR: begin
            alu_op   = ALU_ADD;
            alu_src2 = 1'b1;
            pc_write = 1'b1;
            pc_src   = PC_JALR;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        dmem_req  = 1'b1;
        mem_read  = (cls_q == CLS_LOAD);
        mem_write = (cls_q == CLS_STORE);
        if (dmem_ready) begin
          state_d = (cls_q == CLS_LOAD) ? S_WB : S_FETCH;
        end else if (tmo_expired) begin
          timeout_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        case (cls_q)
          CLS_LOAD:          mem_to_reg = WB_LOAD;
          CLS_JAL, CLS_JALR: mem_to_reg = WB_PC4;
          default:           mem_to_reg = WB_ALU;
        endcase
        state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    // Reset masks every strobe in the same cycle, so an in-flight request drops at once.
    if (rst) begin
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = '0;
      alu_op     = '0;
      alu_src1   = 1'b0;
      alu_src2   = 1'b0;
      mem_to_reg = '0;
      reg_write  = 1'b0;
    end
  end

  assign illegal = illegal_q && !rst;
  assign timeout = timeout_q && !rst;
  assign state   = rst ? 3'd0 : state_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the RV32I core. It replaces single-cycle opcode decoding with an FSM that steps the shared datapath through FETCH, DECODE, EXEC, MEM and WB. It handshakes with the instruction and data memories and raises the per-cycle datapath strobes: PC/IR write, ALU steering, memory request, register write. It sits between the memory ports and the datapath register/ALU muxes.

Parameters:
MEM_TIMEOUT, 15, max wait cycles for imem_ready/dmem_ready before halting; 0 disables the timeout
TMO_W, 4, timeout counter width; must hold MEM_TIMEOUT

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
opcode  in  7  IR[6:0]; valid from DECODE onward
zero  in  1  branch-taken condition from the comparator/ALU
imem_ready  in  1  instruction memory data valid
dmem_ready  in  1  data memory access complete
imem_req  out  1  instruction fetch request
dmem_req  out  1  data memory request
mem_read  out  1  data access is a load
mem_write  out  1  data access is a store
ir_write  out  1  latch IR and old_pc
pc_write  out  1  update PC
pc_src  out  2  00 PC+4, 01 branch target, 10 jal target, 11 ALU result (jalr)
alu_op  out  2  00 add, 01 sub/compare, 10 funct-decoded, 11 pass operand B
alu_src1  out  1  0 rs1, 1 old_pc
alu_src2  out  1  0 rs2, 1 immediate
mem_to_reg  out  2  00 ALU, 01 load data, 10 PC+4
reg_write  out  1  write rd
illegal  out  1  sticky: unknown opcode
timeout  out  1  sticky: memory wait expired
state  out  3  current state, for debug

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Outputs are decoded combinationally from state plus the latched instruction class.
- Reset: on a clk edge with rst=1, state <= FETCH, class <= NONE, counter <= 0, illegal/timeout <= 0. While rst=1 all outputs are forced to 0.
- FETCH: imem_req=1, held until imem_ready. On the ready cycle: ir_write=1, pc_write=1, pc_src=00, next state DECODE.
- DECODE: one cycle. Latch the class from opcode: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111. Any other opcode: illegal <= 1, next state HALT. Otherwise next state EXEC.
- EXEC: one cycle, per class.
  - R: alu_op=10, src2=0, next WB.
  - I-ALU: alu_op=10, src2=1, next WB.
  - LOAD/STORE: alu_op=00, src2=1, next MEM.
  - BRANCH: alu_op=01, src2=0, pc_write=zero, pc_src=01, next FETCH.
  - LUI: alu_op=11, src2=1, next WB.
  - AUIPC: alu_op=00, src1=1, src2=1, next WB.
  - JAL: pc_write=1, pc_src=10, next WB.
  - JALR: alu_op=00, src2=1, pc_write=1, pc_src=11, next WB.
- MEM: dmem_req=1, with mem_read for LOAD or mem_write for STORE, held stable until dmem_ready. On ready: LOAD goes to WB, STORE goes to FETCH.
- WB: reg_write=1 for exactly one cycle. mem_to_reg is 01 for LOAD, 10 for JAL/JALR, 00 otherwise. Next state FETCH.
- Latency with zero-wait memory: BRANCH 3 cycles; R, I-ALU, LUI, AUIPC, JAL, JALR and STORE 4 cycles; LOAD 5 cycles.
- Timeout counter:
  - Cleared on entry to FETCH/MEM; increments each cycle in FETCH/MEM without ready.
  - If the counter reaches MEM_TIMEOUT without ready: timeout <= 1, next state HALT.
  - If ready arrives on the same cycle the limit is hit, ready wins and the counter is cleared.
- HALT: all strobes 0. Only rst exits HALT; illegal/timeout stay high until then.
- Ready inputs outside FETCH/MEM are ignored.
- opcode changes outside DECODE have no effect.
- Reset mid-MEM: request drops in the same cycle rst is high, and no register write occurs.

Decomposition:
- Package rv32i_ctrl_pkg holds:
  - opcode constants
  - state encoding
  - class enum
  - alu_op, pc_src and mem_to_reg codes
- Sub-module wait_timer (TMO_W counter with clear/enable/expired) is instantiated once and shared by FETCH and MEM.

Test Plan:
- R-type 0110011, memories ready immediately -> state sequence FETCH,DECODE,EXEC,WB. reg_write=1 in cycle 4 only, mem_to_reg=00, alu_op=10.
- LOAD 0000011, dmem_ready after 3 wait cycles -> dmem_req/mem_read held 4 cycles, then WB with mem_to_reg=01. Total 8 cycles.
- BRANCH 1100011 with zero=1, then with zero=0 -> pc_write=1 with pc_src=01 in EXEC for the first, pc_write=0 for the second. Both return to FETCH after 3 cycles, no reg_write.
- JAL 1101111 and JALR 1100111 -> pc_src 10 and 11 in EXEC, mem_to_reg=10 with reg_write in WB.
- Opcode 1111111 -> illegal=1 and state HALT after DECODE. Strobes stay 0 for 20 cycles until rst, after which imem_req=1.
- imem_ready held low, MEM_TIMEOUT=15 -> timeout=1 and HALT after 15 cycles. A rerun with ready on cycle 15 continues to DECODE with timeout=0.
